// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of the FIFO write port.
// One producer owns the port for a burst of up to BURST_L words.
// A new burst only starts from IDLE when the FIFO is not almost full.
// Inside a burst the arbiter stalls while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 24,
  parameter int BURST_L = 4
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_almst_full,
  output logic                        busy
);

  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam logic [4:0]         LAST_BEAT = 5'(BURST_L - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]     NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [4:0]           beat_cnt_q;
  logic                 busy_q;

  logic                 owner_req_s;
  logic                 wr_s;
  logic                 burst_end_s;
  logic                 pick_found_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [IDX_W:0]       cand_sum_s;
  logic [IDX_W:0]       cand_idx_s;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [4:0]           beat_cnt_d;

  // Qualify a write: only the owner in BURST, and never into a full FIFO.
  always_comb begin
    owner_req_s = req[owner_q];
    if (state_q == ST_BURST) begin
      wr_s = owner_req_s & ~fifo_full;
    end else begin
      wr_s = 1'b0;
    end
  end

  // Rotating-priority search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IDX_W{1'b0}};
    cand_sum_s   = {(IDX_W+1){1'b0}};
    cand_idx_s   = {(IDX_W+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand_sum_s >= NUM_REQ_W) begin
        cand_idx_s = cand_sum_s - NUM_REQ_W;
      end else begin
        cand_idx_s = cand_sum_s;
      end
      if (!pick_found_s && req[cand_idx_s[IDX_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_idx_s[IDX_W-1:0];
      end else begin
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Burst termination, next priority pointer and beat counter update.
  always_comb begin
    if (state_q == ST_BURST) begin
      burst_end_s = ~owner_req_s | (wr_s & (beat_cnt_q == LAST_BEAT));
    end else begin
      burst_end_s = 1'b0;
    end
    if (owner_q == LAST_IDX) begin
      rr_ptr_d = {IDX_W{1'b0}};
    end else begin
      rr_ptr_d = owner_q + IDX_W'(1'b1);
    end
    if (wr_s) begin
      beat_cnt_d = beat_cnt_q + 5'd1;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Write-port datapath: ack/wr_en follow the write qualifier, data follows the owner.
  always_comb begin
    fifo_wr_en   = wr_s;
    fifo_data_in = {DATA_W{1'b0}};
    if (wr_s) begin
      ack = ONE_HOT0 << owner_q;
    end else begin
      ack = {NUM_REQ{1'b0}};
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == ST_BURST) && (owner_q == IDX_W'(i))) begin
        fifo_data_in = req_data[i*DATA_W +: DATA_W];
      end else begin
        fifo_data_in = fifo_data_in;
      end
    end
  end

  // Arbiter FSM with registered grant and busy.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= {IDX_W{1'b0}};
      rr_ptr_q   <= {IDX_W{1'b0}};
      gnt_q      <= {NUM_REQ{1'b0}};
      beat_cnt_q <= 5'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found_s && !fifo_almst_full) begin
            state_q    <= ST_BURST;
            owner_q    <= pick_idx_s;
            gnt_q      <= ONE_HOT0 << pick_idx_s;
            beat_cnt_q <= 5'd0;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            gnt_q      <= {NUM_REQ{1'b0}};
            busy_q     <= 1'b0;
          end
        end
        ST_BURST: begin
          if (burst_end_s) begin
            state_q    <= ST_IDLE;
            gnt_q      <= {NUM_REQ{1'b0}};
            busy_q     <= 1'b0;
            beat_cnt_q <= 5'd0;
            rr_ptr_q   <= rr_ptr_d;
          end else begin
            beat_cnt_q <= beat_cnt_d;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          owner_q    <= {IDX_W{1'b0}};
          rr_ptr_q   <= {IDX_W{1'b0}};
          gnt_q      <= {NUM_REQ{1'b0}};
          beat_cnt_q <= 5'd0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// checked each cycle against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int BL = 4;
  localparam int IW = $clog2(N);

  logic             clk = 1'b0;
  logic             n_reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     ack;
  logic [N-1:0]     gnt;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_data_in;
  logic             fifo_full;
  logic             fifo_almst_full;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // reference model: who owns the port, how many words written, next priority
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_beats;
  int cnt[N];

  int log_q[$];
  int gnt_log[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_L(BL)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .req             (req),
    .req_data        (req_data),
    .ack             (ack),
    .gnt             (gnt),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almst_full (fifo_almst_full),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // each producer presents {index, word counter}
  function automatic void drive_data();
    logic [N*W-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++)
      t = t | ((N*W)'(W'((i << 16) | (cnt[i] & 32'hFFFF))) << (i*W));
    req_data = t;
  endfunction

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_beats = 0;
  endfunction

  // one clock cycle: called at negedge with inputs already set
  task automatic step();
    logic [N-1:0]  ea, eg;
    logic          ew;
    logic [W-1:0]  ed;
    logic [IW-1:0] oi;
    bit            n_busy;
    int            n_owner, n_ptr, n_beats;
    bit            found;
    drive_data();
    #1;
    oi = IW'(m_owner);
    ew = m_busy && req[oi] && !fifo_full;
    ea = ew ? (N'(1) << m_owner) : '0;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    ed = m_busy ? W'(req_data >> (m_owner*W)) : '0;
    log_q.push_back(fifo_wr_en ? int'(fifo_data_in) : -1);
    gnt_log.push_back(int'(gnt));
    check("ack",      32'(ack),          32'(ea));
    check("wr_en",    32'(fifo_wr_en),   32'(ew));
    check("data",     32'(fifo_data_in), 32'(ed));
    check("gnt",      32'(gnt),          32'(eg));
    check("busy",     32'(busy),         32'(m_busy));
    check("wr_on_full", 32'(fifo_wr_en & fifo_full), 32'd0);
    n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats;
    if (!m_busy) begin
      if (req != '0 && !fifo_almst_full) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!found && req[IW'(c)]) begin
            found = 1'b1; n_owner = c;
          end
        end
        n_busy = 1'b1; n_beats = 0;
      end
    end else if (!req[oi]) begin
      n_busy = 1'b0; n_ptr = (m_owner + 1) % N;
    end else if (ew) begin
      n_beats = m_beats + 1;
      if (n_beats == BL) begin
        n_busy = 1'b0; n_ptr = (m_owner + 1) % N;
      end
    end
    @(posedge clk);
    if (ew) cnt[m_owner]++;
    m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats;
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    #1;
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
  endtask

  // reset asserted between edges; outputs must clear without a clock
  task automatic async_reset_mid();
    #2;
    n_reset = 1'b0;
    #1;
    check("arst_ack",   32'(ack),          32'd0);
    check("arst_wr_en", 32'(fifo_wr_en),   32'd0);
    check("arst_data",  32'(fifo_data_in), 32'd0);
    check("arst_gnt",   32'(gnt),          32'd0);
    check("arst_busy",  32'(busy),         32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
  endtask

  function automatic int owner_of(input int v);
    return (v == -1) ? -1 : (v >> 16);
  endfunction

  initial begin
    int e1w[8] = '{-1, 1, 2, 3, 4, -1, 5, 6};
    int e1g[8] = '{0, 1, 1, 1, 1, 0, 1, 1};
    int e3w[9] = '{-1, 10, -1, -1, -1, 11, 12, 13, -1};
    int e4g[5] = '{0, 0, 0, 0, 4};
    int e5o[6] = '{-1, 0, 0, -1, -1, 1};
    int e5g[6] = '{0, 1, 1, 1, 0, 2};
    int eo, eg;

    n_reset = 1'b0; req = '0; fifo_full = 1'b0; fifo_almst_full = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    model_reset();
    drive_data();
    #1;
    check("reset_ack",   32'(ack),          32'd0);
    check("reset_wr_en", 32'(fifo_wr_en),   32'd0);
    check("reset_data",  32'(fifo_data_in), 32'd0);
    check("reset_gnt",   32'(gnt),          32'd0);
    check("reset_busy",  32'(busy),         32'd0);
    @(negedge clk);
    n_reset = 1'b1;

    // single requester: 1..4, one idle cycle, then 5,6
    cnt[0] = 1; req = 4'b0001;
    log_q.delete(); gnt_log.delete();
    for (int s = 0; s < 8; s++) step();
    for (int s = 0; s < 8; s++) begin
      check("single_wr",  32'(log_q[s]),   32'(e1w[s]));
      check("single_gnt", 32'(gnt_log[s]), 32'(e1g[s]));
    end
    req = '0;
    for (int s = 0; s < 2; s++) step();

    // round-robin fairness with all requesters held
    do_reset();
    req = 4'b1111;
    log_q.delete(); gnt_log.delete();
    for (int s = 0; s < 21; s++) step();
    for (int s = 0; s < 21; s++) begin
      eo = (s % 5 == 0) ? -1 : (s / 5) % 4;
      eg = (s % 5 == 0) ? 0 : (1 << ((s / 5) % 4));
      check("rr_owner", 32'(owner_of(log_q[s])), 32'(eo));
      check("rr_gnt",   32'(gnt_log[s]),         32'(eg));
    end
    req = '0;
    for (int s = 0; s < 3; s++) step();

    // full stall on second beat for three cycles, almost-full ignored in burst
    do_reset();
    cnt[0] = 10; req = 4'b0001;
    log_q.delete(); gnt_log.delete();
    step(); step();
    fifo_full = 1'b1; fifo_almst_full = 1'b1;
    for (int s = 0; s < 3; s++) step();
    fifo_full = 1'b0;
    for (int s = 0; s < 3; s++) step();
    req = '0;
    step();
    fifo_almst_full = 1'b0;
    for (int s = 0; s < 9; s++) check("stall_wr", 32'(log_q[s]), 32'(e3w[s]));

    // almost-full gates a new burst from IDLE
    do_reset();
    fifo_almst_full = 1'b1; req = 4'b0100;
    log_q.delete(); gnt_log.delete();
    for (int s = 0; s < 3; s++) step();
    fifo_almst_full = 1'b0;
    for (int s = 0; s < 2; s++) step();
    for (int s = 0; s < 5; s++) check("afull_gnt", 32'(gnt_log[s]), 32'(e4g[s]));
    req = '0;
    for (int s = 0; s < 2; s++) step();

    // early release moves priority past the owner
    do_reset();
    req = 4'b0011;
    log_q.delete(); gnt_log.delete();
    for (int s = 0; s < 3; s++) step();
    req = 4'b0010;
    step();
    req = 4'b0011;
    for (int s = 0; s < 2; s++) step();
    for (int s = 0; s < 6; s++) begin
      check("rel_owner", 32'(owner_of(log_q[s])), 32'(e5o[s]));
      check("rel_gnt",   32'(gnt_log[s]),         32'(e5g[s]));
    end
    req = '0;
    for (int s = 0; s < 2; s++) step();

    // async reset mid-burst with rr_ptr advanced, then pointer restarts at 0
    do_reset();
    req = 4'b0110;
    for (int s = 0; s < 8; s++) step();
    async_reset_mid();
    gnt_log.delete();
    step(); step();
    check("arst_ptr_gnt0", 32'(gnt_log[0]), 32'd0);
    check("arst_ptr_gnt1", 32'(gnt_log[1]), 32'h2);
    async_reset_mid();
    req = 4'b1000;
    gnt_log.delete();
    step(); step();
    check("arst_req3_gnt0", 32'(gnt_log[0]), 32'd0);
    check("arst_req3_gnt1", 32'(gnt_log[1]), 32'h8);
    req = '0;
    for (int s = 0; s < 2; s++) step();

    // random traffic against the model
    for (int s = 0; s < 1500; s++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      fifo_full       = ($urandom_range(4) == 0);
      fifo_almst_full = fifo_full | ($urandom_range(3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
